// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan controller.
package pattern_scan_pkg;

  // Serialiser states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Pattern loaded out of reset unless overridden
  localparam logic [4:0] DEFAULT_PAT = 5'b10110;

endpackage : pattern_scan_pkg

// File: rtl/pattern_match_core.sv
// Bit-serial pattern matcher: history shift register, fill counter and
// comparator. Flags a hit combinationally for the bit presented this cycle.
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  output logic             match_c
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_nxt_c;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt_c;

  // Next history/fill if the current bit is consumed, and the hit decision
  always_comb begin
    history_nxt_c = {history[PAT_W-2:0], bit_in};
    fill_nxt_c    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match_c       = bit_valid && (fill_nxt_c == FILL_FULL) &&
                    (history_nxt_c == pattern);
  end

  // Pattern, history and fill registers; a load restarts the history
  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern <= RST_PAT;
      history <= '0;
      fill    <= '0;
    end else if (load) begin
      pattern <= pattern_in;
      history <= '0;
      fill    <= '0;
    end else if (bit_valid) begin
      history <= history_nxt_c;
      fill    <= fill_nxt_c;
    end
  end

endmodule : pattern_match_core

// File: rtl/pattern_scan_ctrl.sv
// Pattern scan controller: accepts parallel words, serialises them MSB
// first into the matcher, and counts matches (saturating).
// Optional feature: define PATTERN_SCAN_IRQ_EN to add the sticky irq output
// and its irq_clr input.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned      WORD_W  = 8,
  parameter int unsigned      PAT_W   = 5,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_load,
  input  logic              cnt_clr,
`ifdef PATTERN_SCAN_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(WORD_W - 2);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              accept_c;
  logic              load_ok_c;
  logic              match_c;

  assign accept_c  = word_valid && word_ready;
  assign load_ok_c = cfg_load && (state == IDLE) && !word_valid;

  // Handshake and serialisation FSM; word_ready/busy track the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      word_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state      <= SHIFT;
            shreg      <= word_in;
            idx        <= '0;
            busy       <= 1'b1;
            word_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (idx == IDX_LAST) begin
            if (word_valid) begin
              shreg      <= word_in;
              idx        <= '0;
              word_ready <= 1'b0;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              word_ready <= 1'b1;
            end
          end else begin
            shreg      <= shreg << 1;
            idx        <= idx + IDX_W'(1);
            word_ready <= (idx == IDX_PENULT);
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          word_ready <= 1'b1;
        end
      endcase
    end
  end

  pattern_match_core #(
    .PAT_W   (PAT_W),
    .RST_PAT (RST_PAT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (busy),
    .bit_in     (shreg[WORD_W-1]),
    .load       (load_ok_c),
    .pattern_in (cfg_pattern),
    .match_c    (match_c)
  );

  // Match pulse and saturating counter; clear beats a same-cycle match
  always_ff @(posedge clk) begin
    if (!rst) begin
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else begin
      match_pulse <= match_c;
      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (match_c && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PATTERN_SCAN_IRQ_EN
  // Sticky interrupt; a new match wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq <= 1'b0;
    end else if (match_c) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule : pattern_scan_ctrl

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: directed scenarios plus random traffic,
// checked every cycle against a bit-queue reference model.
module tb_pattern_scan_ctrl;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned PAT_W   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam logic [PAT_W-1:0] RST_PAT = 5'b10110;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_load;
  logic              cnt_clr;
  logic              busy;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_cnt;
`ifdef PATTERN_SCAN_IRQ_EN
  logic              irq_clr;
  logic              irq;
`endif

  always #5 clk = ~clk;

  pattern_scan_ctrl #(
    .WORD_W  (WORD_W),
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .RST_PAT (RST_PAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_load    (cfg_load),
    .cnt_clr     (cnt_clr),
`ifdef PATTERN_SCAN_IRQ_EN
    .irq_clr     (irq_clr),
    .irq         (irq),
`endif
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: bits still to be scanned, plus the recent bit history
  int               m_bits[$];
  logic [31:0]      m_hist;
  int               m_fill;
  logic [PAT_W-1:0] m_pat;
  int               m_cnt;
  bit               m_pulse;
  bit               m_irq;

  int busy_run;
  int pulse_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  function automatic void model_edge();
    bit match;
    bit ready;
    bit load_ok;
    int b;
    logic [31:0] mask;
    match = 1'b0;
    mask  = (32'd1 << PAT_W) - 32'd1;
    if (!rst) begin
      m_bits.delete();
      m_hist  = '0;
      m_fill  = 0;
      m_pat   = RST_PAT;
      m_cnt   = 0;
      m_pulse = 1'b0;
      m_irq   = 1'b0;
      return;
    end
    ready   = (m_bits.size() <= 1);
    load_ok = cfg_load && (m_bits.size() == 0) && !word_valid;
    if (m_bits.size() > 0) begin
      b      = m_bits.pop_front();
      m_hist = (m_hist << 1) | 32'(b);
      if (m_fill < PAT_W) m_fill++;
      match = (m_fill == PAT_W) && ((m_hist & mask) == 32'(m_pat));
    end
    if (word_valid && ready)
      for (int i = WORD_W - 1; i >= 0; i--) m_bits.push_back(int'(word_in[i]));
    if (load_ok) begin
      m_pat  = cfg_pattern;
      m_hist = '0;
      m_fill = 0;
    end
    m_pulse = match;
    if (cnt_clr) m_cnt = 0;
    else if (match && m_cnt < CNT_MAX) m_cnt++;
`ifdef PATTERN_SCAN_IRQ_EN
    if (match) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
`endif
  endfunction

  // One clock: update the model, then compare every output after the edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("word_ready", 32'(word_ready), 32'(m_bits.size() <= 1));
    check("busy", 32'(busy), 32'(m_bits.size() > 0));
    check("match_pulse", 32'(match_pulse), 32'(m_pulse));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
`ifdef PATTERN_SCAN_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
    if (busy) busy_run++;
    if (match_pulse) pulse_seen++;
  endtask

  // Present a word and hold word_valid until the handshake edge
  task automatic send_word(input logic [WORD_W-1:0] w);
    bit acc;
    int budget;
    word_in    = w;
    word_valid = 1'b1;
    budget     = 2 * WORD_W + 4;
    do begin
      acc = (m_bits.size() <= 1);
      step();
      budget--;
    end while (!acc && budget > 0);
    if (!acc) check("send_timeout", 32'd1, 32'd0);
  endtask

  // Drop word_valid and run until the controller goes idle
  task automatic drain();
    int budget;
    word_valid = 1'b0;
    budget     = 2 * WORD_W + 4;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    if (busy) check("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic do_reset(input int cycles);
    word_valid = 1'b0;
    rst        = 1'b0;
    repeat (cycles) step();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    word_in     = '0;
    word_valid  = 1'b0;
    cfg_pattern = '0;
    cfg_load    = 1'b0;
    cnt_clr     = 1'b0;
`ifdef PATTERN_SCAN_IRQ_EN
    irq_clr     = 1'b0;
`endif

    // Reset state
    do_reset(2);
    check("rst_ready", 32'(word_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_pulse", 32'(match_pulse), 32'd0);

    // Default pattern over 0xB6: two matches, eight busy cycles
    busy_run = 0; pulse_seen = 0;
    send_word(8'hB6);
    drain();
    check("b6_cnt", 32'(match_cnt), 32'd2);
    check("b6_pulses", 32'(pulse_seen), 32'd2);
    check("b6_busy", 32'(busy_run), 32'd8);

    // Back-to-back 0xB6, 0xD6: no bubble, cross-word match counted
    do_reset(1);
    busy_run = 0;
    send_word(8'hB6);
    send_word(8'hD6);
    drain();
    check("b2b_cnt", 32'(match_cnt), 32'd4);
    check("b2b_busy", 32'(busy_run), 32'd16);

    // Pattern load while busy is ignored; the same load in idle takes effect
    do_reset(1);
    send_word(8'h00);
    word_valid  = 1'b0;
    cfg_pattern = 5'b11111;
    cfg_load    = 1'b1;
    step();
    cfg_load = 1'b0;
    drain();
    send_word(8'hFF);
    drain();
    check("load_busy_cnt", 32'(match_cnt), 32'd0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    send_word(8'hFF);
    drain();
    check("load_idle_cnt", 32'(match_cnt), 32'd4);

    // Counter clear coinciding with a match, then saturation
    send_word(8'hFF);
    send_word(8'hFF);
    word_valid = 1'b0;
    check("clr_pulse_hi", 32'(match_pulse), 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(match_cnt), 32'd0);
    for (int k = 0; k < 34; k++) send_word(8'hFF);
    drain();
    check("sat_cnt", 32'(match_cnt), 32'(CNT_MAX));
    send_word(8'hFF);
    drain();
    check("sat_hold", 32'(match_cnt), 32'(CNT_MAX));

    // Reset at bit 3 of 0xB6 aborts the word without a pulse
    do_reset(1);
    send_word(8'hB6);
    word_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(word_ready), 32'd1);
    check("abort_pulse", 32'(match_pulse), 32'd0);
    pulse_seen = 0;
    repeat (10) step();
    check("abort_quiet", 32'(pulse_seen), 32'd0);

`ifdef PATTERN_SCAN_IRQ_EN
    // Sticky irq sets on the first match and drops on irq_clr
    check("irq_rst", 32'(irq), 32'd0);
    send_word(8'hB6);
    drain();
    check("irq_set", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 32'd0);
`endif

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 299) != 0);
      word_valid  = ($urandom_range(0, 3) != 0);
      word_in     = WORD_W'($urandom());
      cfg_load    = ($urandom_range(0, 15) == 0);
      cfg_pattern = ($urandom_range(0, 1) != 0) ? RST_PAT : PAT_W'($urandom());
      cnt_clr     = ($urandom_range(0, 63) == 0);
`ifdef PATTERN_SCAN_IRQ_EN
      irq_clr     = ($urandom_range(0, 7) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pattern_scan_ctrl
